// File: rtl/vram_pkg.sv
// Shared definitions for the multi-port video RAM.
// Provides the byte-lane width, the grant record produced by the arbiter,
// the round-robin next-grant search and the flat-vector slice-offset helper.
package vram_pkg;

    localparam int LANE_W    = 8;
    localparam int MAX_PORTS = 8;
    localparam int PIDX_W    = 3;

    typedef struct packed {
        logic              valid;
        logic [PIDX_W-1:0] idx;
    } grant_t;

    // Round-robin search: first pending port at or after (last + 1) mod nports.
    // The previous winner is therefore considered last.
    function automatic grant_t rr_pick(
        input logic [MAX_PORTS-1:0] pend,
        input logic [PIDX_W-1:0]    last,
        input int                   nports
    );
        grant_t g;
        int     cand;
        g.valid = 1'b0;
        g.idx   = {PIDX_W{1'b0}};
        for (int k = 1; k <= MAX_PORTS; k++) begin
            if (k <= nports) begin
                cand = (int'(last) + k) % nports;
                if (!g.valid && pend[cand[PIDX_W-1:0]]) begin
                    g.valid = 1'b1;
                    g.idx   = cand[PIDX_W-1:0];
                end
            end
        end
        return g;
    endfunction

    // Bit offset of element idx inside a flat vector of width-bit elements.
    function automatic int slice_off(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/vram_lane.sv
// One 8-bit byte lane of the video RAM: 2^AW x 8 simple-port block RAM.
// Ports:
//   clk  - system clock
//   we   - write strobe, writes din to addr on the rising edge
//   addr - word address shared by all lanes
//   din  - write byte
//   dout - byte currently stored at addr (captured by the caller)
// Contents are never reset.
module vram_lane
    import vram_pkg::*;
#(
    parameter int AW = 15
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [LANE_W-1:0] din,
    output logic [LANE_W-1:0] dout
);

    logic [LANE_W-1:0] mem_r [0:(1<<AW)-1];

    // Storage write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= din;
        end
    end

    assign dout = mem_r[addr];

endmodule

// File: rtl/vram_mp.sv
// Multi-port video RAM: NPORTS toggle-handshake requesters share one access
// slot per cycle, arbitrated round-robin, onto LANES byte-wide RAM lanes.
// Ports:
//   clk        - system clock
//   reset      - synchronous active-high reset (handshake state only)
//   port_addr  - per-port word address, port i at [i*AW +: AW]
//   port_req   - per-port request toggle
//   port_ack   - per-port acknowledge toggle
//   port_we    - per-port write (1) / read (0)
//   port_be    - per-port lane write enables, ignored on reads
//   port_din   - per-port write data, lane k at [8k +: 8]
//   port_dout  - per-port read data, held until the next read completes
// OUT_REG=0 completes on the grant edge; OUT_REG=1 adds one registered stage
// during which the port stays in flight and cannot be granted again.
module vram_mp
    import vram_pkg::*;
#(
    parameter int NPORTS  = 2,
    parameter int AW      = 15,
    parameter int LANES   = 2,
    parameter int OUT_REG = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NPORTS*AW-1:0]      port_addr,
    input  logic [NPORTS-1:0]         port_req,
    output logic [NPORTS-1:0]         port_ack,
    input  logic [NPORTS-1:0]         port_we,
    input  logic [NPORTS*LANES-1:0]   port_be,
    input  logic [NPORTS*LANES*8-1:0] port_din,
    output logic [NPORTS*LANES*8-1:0] port_dout
);

    localparam int DW = LANE_W * LANES;

    logic [NPORTS-1:0]    ack_r;
    logic [NPORTS*DW-1:0] dout_r;
    logic [PIDX_W-1:0]    last_grant_r;

    logic                 pipe_valid_r;
    logic [PIDX_W-1:0]    pipe_port_r;
    logic                 pipe_rd_r;
    logic [DW-1:0]        pipe_data_r;

    logic [NPORTS-1:0]    inflight_s;
    logic [MAX_PORTS-1:0] pend_s;
    grant_t               gnt_s;
    int                   gi_s;
    logic [AW-1:0]        g_addr_s;
    logic                 g_we_s;
    logic [LANES-1:0]     g_be_s;
    logic [DW-1:0]        g_din_s;
    logic [LANES-1:0]     lane_we_s;
    logic [DW-1:0]        rd_data_s;

    // A port whose access sits in the output stage is not eligible for grant.
    always_comb begin
        inflight_s = {NPORTS{1'b0}};
        for (int i = 0; i < NPORTS; i++) begin
            inflight_s[i] = pipe_valid_r && (pipe_port_r == PIDX_W'(i));
        end
    end

    // Pending ports: request toggled and nothing in flight.
    always_comb begin
        pend_s = {MAX_PORTS{1'b0}};
        for (int i = 0; i < NPORTS; i++) begin
            pend_s[i] = (port_req[i] != ack_r[i]) && !inflight_s[i];
        end
    end

    assign gnt_s = rr_pick(pend_s, last_grant_r, NPORTS);

    // Route the granted port's request onto the shared access slot.
    always_comb begin
        gi_s     = int'(gnt_s.idx);
        g_addr_s = port_addr[slice_off(gi_s, AW) +: AW];
        g_we_s   = port_we[gi_s];
        g_be_s   = port_be[slice_off(gi_s, LANES) +: LANES];
        g_din_s  = port_din[slice_off(gi_s, DW) +: DW];
    end

    // Lane write strobes; a write granted on a reset edge is suppressed.
    always_comb begin
        lane_we_s = {LANES{1'b0}};
        for (int k = 0; k < LANES; k++) begin
            lane_we_s[k] = gnt_s.valid && g_we_s && g_be_s[k] && !reset;
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        vram_lane #(.AW(AW)) u_lane (
            .clk  (clk),
            .we   (lane_we_s[k]),
            .addr (g_addr_s),
            .din  (g_din_s[k*LANE_W +: LANE_W]),
            .dout (rd_data_s[k*LANE_W +: LANE_W])
        );
    end

    // Handshake, arbitration pointer and optional output stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            ack_r        <= {NPORTS{1'b0}};
            dout_r       <= {(NPORTS*DW){1'b0}};
            last_grant_r <= PIDX_W'(NPORTS - 1);
            pipe_valid_r <= 1'b0;
            pipe_port_r  <= {PIDX_W{1'b0}};
            pipe_rd_r    <= 1'b0;
            pipe_data_r  <= {DW{1'b0}};
        end else begin
            if (gnt_s.valid) begin
                last_grant_r <= gnt_s.idx;
            end
            if (OUT_REG == 0) begin
                pipe_valid_r <= 1'b0;
                if (gnt_s.valid) begin
                    ack_r[gi_s] <= ~ack_r[gi_s];
                    if (!g_we_s) begin
                        dout_r[slice_off(gi_s, DW) +: DW] <= rd_data_s;
                    end
                end
            end else begin
                pipe_valid_r <= gnt_s.valid;
                pipe_port_r  <= gnt_s.idx;
                pipe_rd_r    <= gnt_s.valid && !g_we_s;
                if (gnt_s.valid) begin
                    pipe_data_r <= rd_data_s;
                end
                if (pipe_valid_r) begin
                    ack_r[int'(pipe_port_r)] <= ~ack_r[int'(pipe_port_r)];
                    if (pipe_rd_r) begin
                        dout_r[slice_off(int'(pipe_port_r), DW) +: DW] <= pipe_data_r;
                    end
                end
            end
        end
    end

    assign port_ack  = ack_r;
    assign port_dout = dout_r;

endmodule

// File: tb/tb_vram_mp.sv
// Bench for vram_mp: two instances (2 ports / no output register and
// 4 ports / output register) driven by directed and random requesters,
// compared every cycle against a transaction-level model of the memory.
module tb_vram_mp;

    localparam int AW = 15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [1:0]    req0, ack0, we0;
    logic [2*AW-1:0] addr0;
    logic [3:0]    be0;
    logic [31:0]   din0, dout0;
    logic [3:0]    req1, ack1, we1;
    logic [4*AW-1:0] addr1;
    logic [7:0]    be1;
    logic [63:0]   din1, dout1;

    vram_mp #(.NPORTS(2), .AW(AW), .LANES(2), .OUT_REG(0)) dut0 (
        .clk(clk), .reset(rst), .port_addr(addr0), .port_req(req0), .port_ack(ack0),
        .port_we(we0), .port_be(be0), .port_din(din0), .port_dout(dout0));

    vram_mp #(.NPORTS(4), .AW(AW), .LANES(2), .OUT_REG(1)) dut1 (
        .clk(clk), .reset(rst), .port_addr(addr1), .port_req(req1), .port_ack(ack1),
        .port_we(we1), .port_be(be1), .port_din(din1), .port_dout(dout1));

    // requester-side registers
    logic        t_req  [2][4];
    logic        t_we   [2][4];
    logic [14:0] t_addr [2][4];
    logic [1:0]  t_be   [2][4];
    logic [15:0] t_din  [2][4];

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            req0[p] = t_req[0][p];
            we0[p]  = t_we[0][p];
            addr0[p*AW +: AW] = t_addr[0][p];
            be0[p*2 +: 2]     = t_be[0][p];
            din0[p*16 +: 16]  = t_din[0][p];
        end
        for (int p = 0; p < 4; p++) begin
            req1[p] = t_req[1][p];
            we1[p]  = t_we[1][p];
            addr1[p*AW +: AW] = t_addr[1][p];
            be1[p*2 +: 2]     = t_be[1][p];
            din1[p*16 +: 16]  = t_din[1][p];
        end
    end

    // reference model state
    int          errors = 0;
    int          checks = 0;
    logic        mack  [2][4];
    logic [15:0] mdout [2][4];
    logic [15:0] mmask [2][4];
    int          last  [2];
    logic        sv    [2];
    int          sp    [2];
    logic        srd   [2];
    logic [15:0] sdat  [2];
    logic [15:0] smask [2];
    logic [15:0] mem [int];
    logic [1:0]  kn  [int];

    function automatic int np(input int d);
        return (d == 0) ? 2 : 4;
    endfunction

    function automatic logic get_ack(input int d, input int p);
        return (d == 0) ? ack0[p] : ack1[p];
    endfunction

    function automatic logic [15:0] get_dout(input int d, input int p);
        return (d == 0) ? dout0[p*16 +: 16] : dout1[p*16 +: 16];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // What the upcoming clock edge must do for instance d, given current inputs.
    task automatic model_step(input int d);
        int          n;
        int          w;
        int          key;
        logic [15:0] rdat;
        logic [15:0] rmask;
        logic [15:0] tmp;
        logic [1:0]  tkn;
        n = np(d);
        w = -1;
        if (rst) begin
            for (int p = 0; p < 4; p++) begin
                mack[d][p]  = 1'b0;
                mdout[d][p] = 16'h0000;
                mmask[d][p] = 16'hFFFF;
            end
            last[d] = n - 1;
            sv[d]   = 1'b0;
        end else begin
            for (int k = 1; k <= n; k++) begin
                int c;
                c = (last[d] + k) % n;
                if (w < 0 && t_req[d][c] != mack[d][c] && !(sv[d] && sp[d] == c)) w = c;
            end
            if (sv[d]) begin
                mack[d][sp[d]] = ~mack[d][sp[d]];
                if (srd[d]) begin
                    mdout[d][sp[d]] = sdat[d];
                    mmask[d][sp[d]] = smask[d];
                end
                sv[d] = 1'b0;
            end
            if (w >= 0) begin
                last[d] = w;
                key = d * 65536 + int'(t_addr[d][w]);
                if (t_we[d][w]) begin
                    if (!mem.exists(key)) begin
                        mem[key] = 16'h0000;
                        kn[key]  = 2'b00;
                    end
                    tmp = mem[key];
                    tkn = kn[key];
                    for (int k = 0; k < 2; k++) begin
                        if (t_be[d][w][k]) begin
                            tmp[k*8 +: 8] = t_din[d][w][k*8 +: 8];
                            tkn[k] = 1'b1;
                        end
                    end
                    mem[key] = tmp;
                    kn[key]  = tkn;
                    rdat  = mdout[d][w];
                    rmask = mmask[d][w];
                end else if (mem.exists(key)) begin
                    rdat  = mem[key];
                    tkn   = kn[key];
                    rmask = {{8{tkn[1]}}, {8{tkn[0]}}};
                end else begin
                    rdat  = 16'h0000;
                    rmask = 16'h0000;
                end
                if (d == 0) begin
                    mack[d][w]  = ~mack[d][w];
                    mdout[d][w] = rdat;
                    mmask[d][w] = rmask;
                end else begin
                    sv[d]    = 1'b1;
                    sp[d]    = w;
                    srd[d]   = !t_we[d][w];
                    sdat[d]  = rdat;
                    smask[d] = rmask;
                end
            end
        end
    endtask

    // every cycle: outputs of both instances against the model
    always @(posedge clk) begin
        #2;
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < np(d); p++) begin
                chk($sformatf("ack d%0d p%0d", d, p), 64'(get_ack(d, p)), 64'(mack[d][p]));
                chk($sformatf("dout d%0d p%0d", d, p), 64'(get_dout(d, p) & mmask[d][p]),
                    64'(mdout[d][p] & mmask[d][p]));
            end
        end
    end

    task automatic tick();
        model_step(0);
        model_step(1);
        @(negedge clk);
    endtask

    task automatic issue(input int d, input int p, input logic we, input logic [14:0] a,
                         input logic [1:0] be, input logic [15:0] din);
        t_we[d][p]   = we;
        t_addr[d][p] = a;
        t_be[d][p]   = be;
        t_din[d][p]  = din;
        t_req[d][p]  = ~t_req[d][p];
    endtask

    task automatic clear_reqs();
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < 4; p++) t_req[d][p] = 1'b0;
    endtask

    logic [14:0] pool [6];
    logic [1:0]  prev0;
    logic [3:0]  prev1;
    int          cnt [4];

    initial begin
        pool = '{15'h0000, 15'h7FFF, 15'h1234, 15'h0010, 15'h0001, 15'h4000};
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 4; p++) begin
                t_req[d][p] = 1'b0; t_we[d][p] = 1'b0; t_addr[d][p] = 15'h0000;
                t_be[d][p] = 2'b00; t_din[d][p] = 16'h0000;
            end
        end
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // write then read back on port 0
        issue(0, 0, 1'b1, 15'h1234, 2'b11, 16'hBEEF);
        tick();
        chk("wr ack after 1 cycle", 64'(ack0), 64'(2'b01));
        issue(0, 0, 1'b0, 15'h1234, 2'b00, 16'h0000);
        tick();
        chk("rd ack after 1 cycle", 64'(ack0), 64'(2'b00));
        chk("rd dout 1234", 64'(dout0[15:0]), 64'(16'hBEEF));

        // byte-enable merge
        issue(0, 0, 1'b1, 15'h0000, 2'b01, 16'hAA55);
        tick();
        issue(0, 0, 1'b1, 15'h0000, 2'b10, 16'h1100);
        tick();
        issue(0, 0, 1'b0, 15'h0000, 2'b00, 16'h0000);
        tick();
        chk("be merge dout", 64'(dout0[15:0]), 64'(16'h1155));
        chk("be merge ack", 64'(ack0), 64'(2'b01));

        // write on port 0, read of the same word on port 1 the next cycle
        issue(0, 0, 1'b1, 15'h7FFF, 2'b11, 16'h1357);
        tick();
        issue(0, 1, 1'b0, 15'h7FFF, 2'b11, 16'hFFFF);
        tick();
        chk("xport dout", 64'(dout0[31:16]), 64'(16'h1357));
        chk("write keeps dout", 64'(dout0[15:0]), 64'(16'h1155));
        chk("xport ack", 64'(ack0), 64'(2'b10));

        // output-register instance: 2-cycle latency
        issue(1, 2, 1'b1, 15'h0100, 2'b11, 16'hCAFE);
        tick();
        chk("oreg wr ack not at 1", 64'(ack1), 64'(4'b0000));
        tick();
        chk("oreg wr ack at 2", 64'(ack1), 64'(4'b0100));
        issue(1, 2, 1'b0, 15'h0100, 2'b00, 16'h0000);
        tick();
        chk("oreg rd ack not at 1", 64'(ack1), 64'(4'b0100));
        tick();
        chk("oreg rd ack at 2", 64'(ack1), 64'(4'b0000));
        chk("oreg rd dout", 64'(dout1[47:32]), 64'(16'hCAFE));

        // four ports re-requesting on every ack: acks rotate 3,0,1,2,...
        for (int p = 0; p < 4; p++) issue(1, p, 1'b0, 15'h0100, 2'b00, 16'h0000);
        prev1 = ack1;
        for (int j = 0; j < 9; j++) begin
            tick();
            if (j > 0) chk($sformatf("rr4 ack step %0d", j), 64'(ack1 ^ prev1),
                           64'(4'b0001 << ((j + 2) % 4)));
            prev1 = ack1;
            for (int p = 0; p < 4; p++)
                if (mack[1][p] == t_req[1][p]) issue(1, p, 1'b0, 15'h0100, 2'b00, 16'h0000);
        end
        for (int j = 0; j < 6; j++) tick();

        // reset on the grant edge of a port 1 write
        issue(0, 0, 1'b1, 15'h0010, 2'b11, 16'h0000);
        tick();
        issue(0, 1, 1'b1, 15'h0010, 2'b11, 16'hFFFF);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_reqs();
        chk("rst ack0", 64'(ack0), 64'(2'b00));
        chk("rst dout0", 64'(dout0), 64'(32'h0));
        chk("rst ack1", 64'(ack1), 64'(4'h0));
        chk("rst dout1", 64'(dout1), 64'h0);

        // contention after reset: port 0 first, then strict alternation
        cnt = '{0, 0, 0, 0};
        prev0 = ack0;
        for (int j = 0; j < 8; j++) begin
            for (int p = 0; p < 2; p++) begin
                if (mack[0][p] == t_req[0][p] && cnt[p] < 4) begin
                    issue(0, p, 1'b1, 15'h0020 + 15'(p), 2'b11, 16'($urandom));
                    cnt[p]++;
                end
            end
            tick();
            chk($sformatf("contend grant %0d", j), 64'(ack0 ^ prev0), 64'(2'b01 << (j % 2)));
            prev0 = ack0;
        end
        issue(0, 0, 1'b0, 15'h0010, 2'b00, 16'h0000);
        tick();
        chk("suppressed write", 64'(dout0[15:0]), 64'(16'h0000));

        // random traffic on both instances
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 399) == 0) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                clear_reqs();
            end else begin
                for (int d = 0; d < 2; d++) begin
                    for (int p = 0; p < np(d); p++) begin
                        if (t_req[d][p] == mack[d][p] && $urandom_range(0, 2) == 0)
                            issue(d, p, 1'($urandom_range(0, 1)), pool[$urandom_range(0, 5)],
                                  2'($urandom_range(0, 3)), 16'($urandom));
                    end
                end
                tick();
            end
        end
        for (int j = 0; j < 8; j++) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vram_mp.md
Name: vram_mp

Overview:
- Parametrised block-RAM video memory shared by NPORTS requesters, each using the toggle req/ack handshake.
- Memory is LANES independent 8-bit lanes of 2^AW words, so SNES low/high VRAM bytes are a LANES=2 configuration.
- Adds beyond the two-port VRAM: per-lane byte enables, round-robin arbitration of any number of ports onto one access slot per cycle, optional output register stage, synchronous reset of all handshake state.
- Sits between PPU/DMA/CPU VRAM clients and BRAM on the Mega138K build.

Parameters:
- NPORTS, 2, number of requester ports (1..8).
- AW, 15, word address width per lane.
- LANES, 2, number of 8-bit byte lanes; DW = 8*LANES.
- OUT_REG, 0, 0 = ack/dout one edge after grant; 1 = one extra registered stage.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- port_addr  in  NPORTS*AW  word address, port i at [i*AW +: AW].
- port_req  in  NPORTS  request toggle per port.
- port_ack  out  NPORTS  acknowledge toggle per port.
- port_we  in  NPORTS  1 = write, 0 = read.
- port_be  in  NPORTS*LANES  lane write enables, ignored on reads.
- port_din  in  NPORTS*DW  write data, lane k at bits [8k +: 8].
- port_dout  out  NPORTS*DW  read data per port.

Behaviour:
- Handshake:
  - Port i is pending when port_req[i] != port_ack[i] and it has no access in flight.
  - A requester toggles req only when req == ack.
  - addr/we/be/din must be held stable from the req toggle until the matching ack toggle.
- Arbitration:
  - Combinational each cycle, one grant per cycle among pending ports.
  - Round-robin: search starts at (last_grant+1) mod NPORTS; last_grant updates on each grant.
  - With no pending port, the slot idles and last_grant is unchanged.
- Write on grant edge:
  - Lane k at addr is written with din lane k iff be[k].
  - port_dout[i] is unchanged.
  - be == 0 performs no write but still acks.
- Read on grant edge:
  - All lanes at addr are read; be is ignored.
- Completion timing:
  - OUT_REG=0: port_ack[i] toggles and port_dout[i] updates on the grant edge (one clock after pending is visible). A port may re-request immediately after and be granted the next cycle.
  - OUT_REG=1: data and ack are registered one further edge. The port stays in flight, ineligible for grant, for that extra cycle.
- Latency:
  - Uncontended latency is 1 cycle (OUT_REG=0) or 2 cycles (OUT_REG=1) from the first cycle req != ack.
  - Worst case adds NPORTS-1 cycles.
- Ordering: accesses commit in grant order. A read granted after a write to the same address returns the new data, including when the two accesses come from different ports.
- Reset (synchronous):
  - port_ack=0, port_dout=0, last_grant=NPORTS-1 (so port 0 wins first), in-flight flags and pipeline cleared.
  - A write whose grant edge coincides with reset is suppressed.
  - Accesses in flight are dropped with no ack.
  - Memory contents are preserved.
  - Requesters reset req to 0 on the same reset.
- Width rules: lane k of port i selects bits [i*DW + 8k +: 8]. Addresses are AW bits with no wrap logic; the full range is valid.

Decomposition:
- Package vram_pkg:
  - Lane width constant 8.
  - Function for the round-robin next-grant search.
  - Function for flat-vector slice offsets.
- One sub-module, vram_lane: a single 2^AW x 8 simple-port BRAM with we/addr/din/dout. Instantiated LANES times from a generate loop; a shared granted address feeds all lanes.

Test Plan:
- NPORTS=2, LANES=2, OUT_REG=0:
  - Port0 writes addr 0x1234 din 0xBEEF be=11, then reads 0x1234 → ack toggles 1 cycle after each req, dout=0xBEEF.
  - Byte enables: write 0x0000 be=01 din=0xAA55, then be=10 din=0x1100, read → 0x1155.
  - Contention: both ports toggle req in the same cycle for 4 back-to-back requests each → grants alternate 0,1,0,1…, each port sees 2-cycle ack spacing, no starvation.
- NPORTS=4, OUT_REG=1:
  - Single read of a preloaded word → ack and dout arrive 2 cycles after the req toggle.
  - Port re-toggling req each ack is never granted twice in a row while others pend.
- Reset mid-operation: assert reset on port1's write grant edge (addr 0x0010, prior value 0x0000) → word stays 0x0000, all ack=0, dout=0. After reset, port0 wins the first simultaneous grant.
- Cross-port ordering: port0 writes 0x7FFF←0x1357, port1 reads 0x7FFF the next cycle → port1 dout=0x1357.
